// File: rtl/proc_pkg.sv
// Shared processor package: state encodings and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

  localparam int AW_DEF = 18;
  localparam int DW_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_LATCH  = 3'd2,
    ST_XFER   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } mc_state_t;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter; expired is high while the count equals TIMEOUT.
// Latency: count updates on the clock edge; expired is decoded from the count register.
// Backpressure: none; clr has priority over en, and the count holds at TIMEOUT.
// Ports: clk, rst (async active-low), clr (zero the count), en (count one cycle), expired.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Wide enough to hold TIMEOUT itself; guard the TIMEOUT=0 corner.
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TMAX)) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TMAX);

endmodule

// File: rtl/mem_ctrl.sv
// Memory access controller between the control unit / MDR and a handshaked memory.
// Latency: read (zero-wait) req@0 -> ACCESS 1, LATCH 2, XFER 3, DONE 4; write ACCESS 1, DONE 2.
// Backpressure: req is only sampled in IDLE (busy=0); requests while busy are dropped.
// Ports: req/we/addr/wdata from the control unit; busy/done/err status; wr_MDR_Mem and
//        re_MDR MDR strobes; mem_addr/mem_wdata/mem_en/mem_we/mem_ack memory side.
module mem_ctrl
  import proc_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wr_MDR_Mem,
  output logic          re_MDR,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_en,
  output logic          mem_we,
  input  logic          mem_ack
);

  mc_state_t state;
  mc_state_t state_nxt;
  logic      we_q;
  logic      accept;
  logic      timer_en;
  logic      expired;

  assign accept   = (state == ST_IDLE) && req;
  // Count only the ACCESS cycles that end without an ack.
  assign timer_en = (state == ST_ACCESS) && !mem_ack;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (timer_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ack is checked before expiry so a last-cycle ack completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (req) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack)      state_nxt = we_q ? ST_DONE : ST_LATCH;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_LATCH:  state_nxt = ST_XFER;
      ST_XFER:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only (plus the latched access type).
  always_comb begin
    busy       = (state != ST_IDLE);
    mem_en     = (state == ST_ACCESS);
    mem_we     = (state == ST_ACCESS) && we_q;
    wr_MDR_Mem = (state == ST_LATCH);
    re_MDR     = (state == ST_XFER);
    done       = (state == ST_DONE);
    err        = (state == ST_ERR);
  end

  // Access parameters are captured once at acceptance and held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      we_q      <= we;
      mem_addr  <= addr;
      mem_wdata <= wdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with hand-computed expected values.
// Latency: inputs change and outputs are sampled 1 time unit after the falling edge.
// Backpressure: the bench plays the memory, driving mem_ack directly.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [17:0] addr;
  logic [17:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        wr_MDR_Mem;
  logic        re_MDR;
  logic [17:0] mem_addr;
  logic [17:0] mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic        mem_ack;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  // Running pulse counters, sampled on the falling edge.
  int wr_cnt   = 0;
  int re_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr0, re0, done0, err0;

  mem_ctrl #(
    .AW      (18),
    .DW      (18),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .wr_MDR_Mem (wr_MDR_Mem),
    .re_MDR     (re_MDR),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_MDR_Mem === 1'b1) wr_cnt++;
    if (re_MDR === 1'b1) re_cnt++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic snap;
    wr0   = wr_cnt;
    re0   = re_cnt;
    done0 = done_cnt;
    err0  = err_cnt;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mem_ack = 1'b0;
    #2;
    // Reset state
    check_vec("rst_ctl", {busy, done, err, mem_en, mem_we, wr_MDR_Mem, re_MDR}, 32'h0);
    check_vec("rst_addr", mem_addr, 32'h0);
    check_vec("rst_wdata", mem_wdata, 32'h0);
    step;
    step;
    rst = 1'b1;

    // Zero-wait read of 0x00A5
    we = 1'b0; addr = 18'h00A5; wdata = 18'h1234; req = 1'b1;
    step;                                           // cycle 1: ACCESS
    req = 1'b0;
    check_vec("rd_busy", busy, 1);
    check_vec("rd_en_we", {mem_en, mem_we}, 2'b10);
    check_vec("rd_addr", mem_addr, 18'h00A5);
    mem_ack = 1'b1;
    step;                                           // cycle 2: LATCH
    mem_ack = 1'b0;
    check_vec("rd_latch", {wr_MDR_Mem, re_MDR, mem_en}, 3'b100);
    step;                                           // cycle 3: XFER
    check_vec("rd_xfer", {wr_MDR_Mem, re_MDR}, 2'b01);
    step;                                           // cycle 4: DONE
    check_vec("rd_done", {done, busy, err}, 3'b110);
    step;                                           // cycle 5: IDLE
    check_vec("rd_idle", {done, busy}, 2'b00);

    // Write with 3 wait cycles; inputs change after acceptance to prove latching
    we = 1'b1; addr = 18'h0100; wdata = 18'h3FFFF; req = 1'b1;
    snap();
    step;
    req = 1'b0; addr = 18'h0; wdata = 18'h0; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_vec("wr_we", {mem_en, mem_we}, 2'b11);
      check_vec("wr_addr", mem_addr, 18'h0100);
      check_vec("wr_data", mem_wdata, 18'h3FFFF);
      if (i == 3) mem_ack = 1'b1;
      step;
    end
    mem_ack = 1'b0;
    check_vec("wr_done", {done, mem_en, mem_we}, 3'b100);
    step;
    check_vec("wr_idle", busy, 0);
    check_vec("wr_no_strobe", (wr_cnt - wr0) + (re_cnt - re0), 0);
    check_vec("wr_done_cnt", done_cnt - done0, 1);

    // Timeout: no ack for 16 ACCESS cycles -> err in cycle 17
    addr = 18'h0ABC; req = 1'b1;
    snap();
    step;                                           // cycle 1
    req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_vec("to_wait", {mem_en, err}, 2'b10);
      step;
    end
    check_vec("to_err", {err, done, busy, mem_en}, 4'b1010);
    step;
    check_vec("to_idle", {busy, err}, 2'b00);
    check_vec("to_counts", {done_cnt - done0, wr_cnt - wr0, err_cnt - err0}, {32'd0, 32'd0, 32'd1});

    // Back-to-back acceptance in the IDLE cycle after ERR; ack exactly at the limit
    addr = 18'h0DEF; req = 1'b1;
    snap();
    step;                                           // cycle 1
    req = 1'b0;
    check_vec("b2b_accept", {busy, mem_en}, 2'b11);
    for (int k = 0; k < 15; k++) step;              // cycle 16: count == TIMEOUT
    check_vec("lim_still_access", {mem_en, err}, 2'b10);
    mem_ack = 1'b1;
    step;                                           // cycle 17: LATCH
    mem_ack = 1'b0;
    check_vec("lim_latch", {wr_MDR_Mem, err}, 2'b10);
    step;
    step;                                           // cycle 19: DONE
    check_vec("lim_done", {done, err}, 2'b10);
    step;
    check_vec("lim_err_cnt", err_cnt - err0, 0);

    // Stray ack in IDLE, then req pulses during ACCESS and LATCH
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    check_vec("stray_ack", {busy, mem_en}, 2'b00);
    addr = 18'h0033; req = 1'b1;
    snap();
    step;                                           // cycle 1: ACCESS
    req = 1'b1; addr = 18'h0077;
    step;                                           // cycle 2: ACCESS
    req = 1'b0; mem_ack = 1'b1;
    check_vec("ign_access", {mem_en, mem_addr}, {1'b1, 18'h0033});
    step;                                           // cycle 3: LATCH
    mem_ack = 1'b0; req = 1'b1;
    check_vec("ign_latch", {wr_MDR_Mem, mem_addr}, {1'b1, 18'h0033});
    step;                                           // cycle 4: XFER
    req = 1'b0;
    step;                                           // cycle 5: DONE
    check_vec("ign_done", done, 1);
    step;
    step;
    check_vec("ign_not_queued", busy, 0);
    check_vec("ign_counts", {done_cnt - done0, wr_cnt - wr0}, {32'd1, 32'd1});

    // Reset asserted in LATCH, then a normal read of 0x0001
    addr = 18'h0055; req = 1'b1;
    snap();
    step;
    req = 1'b0; mem_ack = 1'b1;
    step;                                           // LATCH
    mem_ack = 1'b0;
    check_vec("rst_pre", wr_MDR_Mem, 1);
    rst = 1'b0;
    #1;
    check_vec("rst_async_ctl", {busy, done, err, mem_en, mem_we, wr_MDR_Mem, re_MDR}, 32'h0);
    check_vec("rst_async_addr", mem_addr, 32'h0);
    step;
    step;
    rst = 1'b1;
    check_vec("rst_no_pulse", {done_cnt - done0, err_cnt - err0}, {32'd0, 32'd0});
    addr = 18'h0001; req = 1'b1;
    step;                                           // first edge after release
    req = 1'b0;
    check_vec("post_rst_accept", {busy, mem_en, mem_addr}, {1'b1, 1'b1, 18'h0001});
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    step;
    step;
    check_vec("post_rst_done", done, 1);
    step;
    check_vec("post_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter AW, default 18, memory address width in bits.
REQ-002 Parameter DW, default 18, memory data width in bits.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack before an access is aborted.
REQ-004 clk  input  1  single clock; all state changes occur on the posedge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  access request from the control unit, sampled only in IDLE.
REQ-007 we  input  1  access type: 1 = write, 0 = read; sampled with req.
REQ-008 addr  input  AW  address from the memory address register; sampled with req.
REQ-009 wdata  input  DW  write data from MDRout; sampled with req.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 err  output  1  one-cycle pulse on timeout abort.
REQ-013 wr_MDR_Mem  output  1  one-cycle strobe; MDR captures MDRinMem (= mem_rdata) on that edge.
REQ-014 re_MDR  output  1  one-cycle strobe; MDR drives the captured word onto MDRout.
REQ-015 mem_addr  output  AW  latched access address.
REQ-016 mem_wdata  output  DW  latched write data.
REQ-017 mem_en  output  1  memory access enable.
REQ-018 mem_we  output  1  memory write enable; qualified by mem_en.
REQ-019 mem_ack  input  1  memory completion; read data on mem_rdata is valid in the same cycle.

Function
REQ-020 States SHALL be IDLE, ACCESS, LATCH, XFER, DONE and ERR.
REQ-021 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from any input to any output.
REQ-022 IDLE: on req=1, latch we, addr and wdata, clear the wait counter, and go to ACCESS; otherwise stay in IDLE.
REQ-023 ACCESS: mem_en=1 and mem_we=latched we; mem_addr and mem_wdata SHALL stay constant.
REQ-024 ACCESS: the wait counter SHALL increment once per cycle in which mem_ack=0.
REQ-025 ACCESS exit on mem_ack=1 (counter not yet at TIMEOUT): read goes to LATCH; write goes to DONE.
REQ-026 ACCESS exit on counter = TIMEOUT with mem_ack=0: go to ERR.
REQ-027 If mem_ack=1 in the same cycle the counter reaches TIMEOUT, the ack SHALL win.
REQ-028 LATCH: wr_MDR_Mem=1 for exactly one cycle, mem_en=0; next state is XFER.
REQ-029 XFER: re_MDR=1 for exactly one cycle; next state is DONE.
REQ-030 DONE: done=1 for one cycle, then go to IDLE.
REQ-031 ERR: err=1 for one cycle, then go to IDLE; no MDR strobe SHALL be issued.
REQ-032 Read latency with a zero-wait memory (ack in the first ACCESS cycle): req sampled at edge 0 gives ACCESS at 1, LATCH at 2, XFER at 3, DONE at 4, IDLE at 5.
REQ-033 Write latency with a zero-wait memory: ACCESS at 1, DONE at 2, IDLE at 3.
REQ-034 req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-035 mem_ack outside ACCESS SHALL be ignored.
REQ-036 A new request is accepted in IDLE in the cycle immediately after DONE or ERR.
REQ-037 The wait counter width SHALL be clog2(TIMEOUT+1) bits and SHALL saturate at TIMEOUT, never wrapping.

Reset
REQ-038 rst=0 SHALL immediately force state IDLE and clear the wait counter and all outputs (mem_addr, mem_wdata, mem_en, mem_we, wr_MDR_Mem, re_MDR, busy, done, err) to 0.
REQ-039 Reset asserted mid-access SHALL abandon the access with no done or err pulse.
REQ-040 After reset release, the first req is accepted on the first clock edge.

Structure
REQ-041 State encodings and the AW/DW defaults SHALL reside in the shared processor package proc_pkg.
REQ-042 The wait counter SHALL be a sub-module, wait_timer (inputs: clr, en; output: expired).

Verification
REQ-043 Read, zero-wait: addr=18'h00A5, mem_ack in the first ACCESS cycle, mem_rdata=18'h2B3C -> wr_MDR_Mem at cycle 2, re_MDR at 3, done at 4.
REQ-044 Write, 3 wait cycles: we=1, addr=18'h0100, wdata=18'h3FFFF -> mem_we held 4 cycles with stable address and data, done pulse, no MDR strobes.
REQ-045 Timeout: mem_ack held 0 -> err pulses TIMEOUT+1 cycles after entering ACCESS, no done, busy=0 the following cycle.
REQ-046 Ack in the same cycle the counter reaches TIMEOUT -> completion path taken (done pulse), err stays 0.
REQ-047 req pulses during ACCESS and LATCH, plus a stray mem_ack in IDLE -> exactly one access, state unaffected.
REQ-048 rst=0 asserted in LATCH -> all outputs 0 asynchronously; after release, a read of 18'h0001 completes normally.
